// File: rtl/wb_queue.sv
// wb_queue: in-order writeback FIFO feeding the register file write port, with pending-write forwarding
module wb_queue #(
    parameter int N     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [4:0]               in_addr,
    input  logic [N-1:0]             in_data,
    input  logic                     stall,
    output logic                     w,
    output logic [4:0]               Waddr,
    output logic [N-1:0]             Wdata,
    input  logic [4:0]               q_addr1,
    input  logic [4:0]               q_addr2,
    output logic                     q_busy1,
    output logic                     q_busy2,
    output logic [N-1:0]             q_data1,
    output logic [N-1:0]             q_data2,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [4:0]    addr_q [DEPTH];
    logic [N-1:0]  data_q [DEPTH];
    logic [AW-1:0] head, tail;
    logic          push, pop;

    assign in_ready = count < (AW+1)'(DEPTH);
    assign push     = in_valid & in_ready & (in_addr != 5'd0);
    assign pop      = (count != '0) & ~stall;

    // Entry storage needs no reset; validity comes from head/count.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail] <= in_addr;
            data_q[tail] <= in_data;
        end
    end

    // Pointers, occupancy and the registered register-file write port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            w     <= 1'b0;
            Waddr <= '0;
            Wdata <= '0;
        end else begin
            w     <= pop;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            if (push) tail <= tail + 1'b1;
            if (pop) begin
                head  <= head + 1'b1;
                Waddr <= addr_q[head];
                Wdata <= data_q[head];
            end
        end
    end

    // Scan oldest to youngest so the youngest match wins; the in-flight write is the lowest priority.
    function automatic logic [N:0] lookup(input logic [4:0] a);
        logic [N:0]    r;
        logic [AW-1:0] idx;
        r = (w && Waddr == a) ? {1'b1, Wdata} : '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + AW'(i);
            if ((AW+1)'(i) < count && addr_q[idx] == a) r = {1'b1, data_q[idx]};
        end
        return (a == 5'd0) ? '0 : r;
    endfunction

    // Two independent hazard/forward query ports.
    always_comb begin
        {q_busy1, q_data1} = lookup(q_addr1);
        {q_busy2, q_data2} = lookup(q_addr2);
    end
endmodule
